// File: rtl/hazard_unit_if.sv
// hazard_unit_if
//
// Bundles the pipeline-side signals exchanged between the 5-stage core and
// its hazard controller. clk/rst are kept out of the bundle and travel as
// plain ports on the modules that use it.
//
// Modports
//   master : pipeline side. Drives the decoded ID/EX/MEM fields and consumes
//            the stall/flush controls.
//   slave  : hazard controller side. Consumes the pipeline fields and
//            drives the stall/flush controls.
//
// Signals
//   IF_ID_RegisterRs/Rt  [4:0]  source registers of the instruction in ID
//   ID_Branch                   ID holds a conditional branch
//   ID_Branch_taken             branch compare result in ID
//   ID_Jump                     ID holds a jump
//   ID_EX_MemRead               EX holds a load
//   ID_EX_RegWrite              EX writes a register
//   ID_EX_WriteReg       [4:0]  EX destination register (post RegDst)
//   EX_MEM_MemRead              MEM holds a load
//   EX_MEM_WriteReg      [4:0]  MEM destination register
//   ID_Hazard_lwstall           load-use bubble into ID_EX
//   ID_Hazard_Branch            branch-dependency bubble into ID_EX
//   PC_Write                    PC update enable
//   IF_ID_Write                 IF_ID update enable
//   IF_Flush                    zero IF_ID on the next edge

interface hazard_unit_if;

   logic [4:0] IF_ID_RegisterRs;
   logic [4:0] IF_ID_RegisterRt;
   logic       ID_Branch;
   logic       ID_Branch_taken;
   logic       ID_Jump;
   logic       ID_EX_MemRead;
   logic       ID_EX_RegWrite;
   logic [4:0] ID_EX_WriteReg;
   logic       EX_MEM_MemRead;
   logic [4:0] EX_MEM_WriteReg;

   logic       ID_Hazard_lwstall;
   logic       ID_Hazard_Branch;
   logic       PC_Write;
   logic       IF_ID_Write;
   logic       IF_Flush;

   modport master (
      output IF_ID_RegisterRs,
      output IF_ID_RegisterRt,
      output ID_Branch,
      output ID_Branch_taken,
      output ID_Jump,
      output ID_EX_MemRead,
      output ID_EX_RegWrite,
      output ID_EX_WriteReg,
      output EX_MEM_MemRead,
      output EX_MEM_WriteReg,
      input  ID_Hazard_lwstall,
      input  ID_Hazard_Branch,
      input  PC_Write,
      input  IF_ID_Write,
      input  IF_Flush
   );

   modport slave (
      input  IF_ID_RegisterRs,
      input  IF_ID_RegisterRt,
      input  ID_Branch,
      input  ID_Branch_taken,
      input  ID_Jump,
      input  ID_EX_MemRead,
      input  ID_EX_RegWrite,
      input  ID_EX_WriteReg,
      input  EX_MEM_MemRead,
      input  EX_MEM_WriteReg,
      output ID_Hazard_lwstall,
      output ID_Hazard_Branch,
      output PC_Write,
      output IF_ID_Write,
      output IF_Flush
   );

endinterface

// File: rtl/hazard_unit.sv
// hazard_unit
//
// Pipeline hazard controller for the 5-stage MIPS core. Watches IF_ID,
// ID_EX and EX_MEM; inserts bubbles into ID_EX and holds PC/IF_ID while an
// operand is not yet available, and flushes IF when a branch is taken or a
// jump is decoded in ID. A two-state FSM stretches the stall to two cycles
// when a branch in ID depends on a load in EX.
//
// All outputs are combinational from the current inputs and state, so the
// enables take effect in the same cycle the hazard is seen.
//
// Ports
//   clk                   clock, all state updates on posedge
//   rst                   synchronous active-high reset
//   hz (hazard_unit_if.slave)
//                         pipeline fields in, stall/flush controls out
//   stall_cycles [31:0]   saturating count of stalled cycles
//                         (only with HAZARD_PERF_EN)
//   flush_count  [31:0]   saturating count of IF flush cycles
//                         (only with HAZARD_PERF_EN)
//
// Build option
//   HAZARD_PERF_EN        when defined, adds the two performance counters
//                         and their ports; behaviour is otherwise identical.
//
// FSM states
//   state | meaning
//   RUN   | evaluate hazards every cycle; stall only while one is present
//   HOLD  | second cycle of a branch-on-load stall; stall unconditionally

module hazard_unit (
   input  logic               clk,
   input  logic               rst,
   hazard_unit_if.slave       hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        flush_count
`endif
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t state;

   logic ex_match;
   logic mem_match;
   logic lw_use;
   logic br_lw;
   logic br_alu;
   logic br_mem;
   logic stall;

   // Register $0 is hardwired to zero, so a write to it never creates a
   // true dependency.
   function automatic logic reg_match(
      input logic [4:0] r,
      input logic [4:0] rs,
      input logic [4:0] rt
   );
      return (r != 5'd0) && ((r == rs) || (r == rt));
   endfunction

   always_comb begin
      ex_match  = reg_match(hz.ID_EX_WriteReg,  hz.IF_ID_RegisterRs, hz.IF_ID_RegisterRt);
      mem_match = reg_match(hz.EX_MEM_WriteReg, hz.IF_ID_RegisterRs, hz.IF_ID_RegisterRt);

      lw_use = hz.ID_EX_MemRead && ex_match;
      br_lw  = hz.ID_Branch && hz.ID_EX_MemRead && ex_match;
      br_alu = hz.ID_Branch && hz.ID_EX_RegWrite && !hz.ID_EX_MemRead && ex_match;
      br_mem = hz.ID_Branch && hz.EX_MEM_MemRead && mem_match;

      if (state == HOLD) begin
         stall = 1'b1;
      end else begin
         stall = lw_use || br_lw || br_alu || br_mem;
      end
   end

   // Output decode. Reset overrides everything, a stall overrides any
   // flush, and a branch outcome is only acted on in a non-stalled cycle.
   always_comb begin
      hz.ID_Hazard_lwstall = 1'b0;
      hz.ID_Hazard_Branch  = 1'b0;
      hz.PC_Write          = 1'b1;
      hz.IF_ID_Write       = 1'b1;
      hz.IF_Flush          = 1'b0;

      if (rst) begin
         hz.ID_Hazard_lwstall = 1'b0;
         hz.ID_Hazard_Branch  = 1'b0;
         hz.PC_Write          = 1'b1;
         hz.IF_ID_Write       = 1'b1;
         hz.IF_Flush          = 1'b0;
      end else if (stall) begin
         hz.PC_Write    = 1'b0;
         hz.IF_ID_Write = 1'b0;
         hz.IF_Flush    = 1'b0;
         // HOLD is always a branch bubble even if ID_Branch has dropped,
         // so the two bubble flags stay mutually exclusive.
         if ((state == HOLD) || hz.ID_Branch) begin
            hz.ID_Hazard_Branch = 1'b1;
         end else begin
            hz.ID_Hazard_lwstall = 1'b1;
         end
      end else begin
         hz.IF_Flush = hz.ID_Jump || (hz.ID_Branch && hz.ID_Branch_taken);
      end
   end

   // In HOLD the load has moved to MEM, so br_mem is also true there; the
   // FSM still returns to RUN after one HOLD cycle, and in RUN the load has
   // left MEM, so no third stall cycle appears.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (br_lw) begin
                  state <= HOLD;
               end else begin
                  state <= RUN;
               end
            end
            HOLD: begin
               state <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (hz.IF_Flush && (flush_count != 32'hFFFF_FFFF)) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

   logic clk;
   logic rst;

   hazard_unit_if hif ();

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   hazard_unit dut (
      .clk          (clk),
      .rst          (rst),
      .hz           (hif)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       br;
      logic       tk;
      logic       jp;
      logic       exmr;
      logic       exrw;
      logic [4:0] exwr;
      logic       memmr;
      logic [4:0] memwr;
   } stim_t;

   // Expected vector order: {lwstall, branch, pc_write, if_id_write, if_flush}
   localparam logic [4:0] E_OK  = 5'b00110;
   localparam logic [4:0] E_LW  = 5'b10000;
   localparam logic [4:0] E_BR  = 5'b01000;
   localparam logic [4:0] E_FL  = 5'b00111;

   int checks = 0;
   int errors = 0;

   logic [4:0] exp_q[$];

   function automatic stim_t st(
      input logic       r,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       br,
      input logic       tk,
      input logic       jp,
      input logic       exmr,
      input logic       exrw,
      input logic [4:0] exwr,
      input logic       memmr,
      input logic [4:0] memwr
   );
      stim_t s;
      s.rst = r; s.rs = rs; s.rt = rt; s.br = br; s.tk = tk; s.jp = jp;
      s.exmr = exmr; s.exrw = exrw; s.exwr = exwr;
      s.memmr = memmr; s.memwr = memwr;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst                   = s.rst;
      hif.IF_ID_RegisterRs  = s.rs;
      hif.IF_ID_RegisterRt  = s.rt;
      hif.ID_Branch         = s.br;
      hif.ID_Branch_taken   = s.tk;
      hif.ID_Jump           = s.jp;
      hif.ID_EX_MemRead     = s.exmr;
      hif.ID_EX_RegWrite    = s.exrw;
      hif.ID_EX_WriteReg    = s.exwr;
      hif.EX_MEM_MemRead    = s.memmr;
      hif.EX_MEM_WriteReg   = s.memwr;
   endtask

   function automatic logic [4:0] observed();
      return {hif.ID_Hazard_lwstall, hif.ID_Hazard_Branch,
              hif.PC_Write, hif.IF_ID_Write, hif.IF_Flush};
   endfunction

   task automatic test_reset();
      stim_t sq[$];
      logic [4:0] ev[$];
      logic [4:0] got, e;
      // load-use hazard present while in reset must be masked
      sq.push_back(st(1, 5'd2, 5'd0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0)); ev.push_back(E_OK);
      sq.push_back(st(1, 5'd0, 5'd0, 1, 1, 1, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      sq.push_back(st(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      foreach (sq[i]) begin
         @(negedge clk);
         apply(sq[i]);
         exp_q.push_back(ev[i]);
         #1;
         got = observed();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset[%0d] got=%b expected=%b", i, got, e);
         end
      end
   endtask

   task automatic test_lw_use();
      stim_t sq[$];
      logic [4:0] ev[$];
      logic [4:0] got, e;
      // lw $2 in EX, Rs=2: one bubble, then the load has moved to MEM
      sq.push_back(st(0, 5'd2, 5'd9, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0)); ev.push_back(E_LW);
      sq.push_back(st(0, 5'd2, 5'd9, 0, 0, 0, 0, 0, 5'd0, 1, 5'd2)); ev.push_back(E_OK);
      // match on Rt
      sq.push_back(st(0, 5'd4, 5'd3, 0, 0, 0, 1, 1, 5'd3, 0, 5'd0)); ev.push_back(E_LW);
      sq.push_back(st(0, 5'd4, 5'd3, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      // load to $0 never stalls
      sq.push_back(st(0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      // load to an unrelated register
      sq.push_back(st(0, 5'd1, 5'd2, 0, 0, 0, 1, 1, 5'd6, 0, 5'd0)); ev.push_back(E_OK);
      foreach (sq[i]) begin
         @(negedge clk);
         apply(sq[i]);
         exp_q.push_back(ev[i]);
         #1;
         got = observed();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL lw_use[%0d] got=%b expected=%b", i, got, e);
         end
      end
   endtask

   task automatic test_branch_on_load();
      stim_t sq[$];
      logic [4:0] ev[$];
      logic [4:0] got, e;
      // beq with lw $5 in EX, Rt=5 -> two cycles of branch bubble, then resolve
      sq.push_back(st(0, 5'd1, 5'd5, 1, 0, 0, 1, 1, 5'd5, 0, 5'd0)); ev.push_back(E_BR);
      sq.push_back(st(0, 5'd1, 5'd5, 1, 0, 0, 0, 0, 5'd0, 1, 5'd5)); ev.push_back(E_BR);
      sq.push_back(st(0, 5'd1, 5'd5, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_FL);
      // HOLD stalls unconditionally even with idle inputs
      sq.push_back(st(0, 5'd8, 5'd0, 1, 0, 0, 1, 1, 5'd8, 0, 5'd0)); ev.push_back(E_BR);
      sq.push_back(st(0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_BR);
      sq.push_back(st(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      foreach (sq[i]) begin
         @(negedge clk);
         apply(sq[i]);
         exp_q.push_back(ev[i]);
         #1;
         got = observed();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL br_lw[%0d] got=%b expected=%b", i, got, e);
         end
      end
   endtask

   task automatic test_branch_alu_mem();
      stim_t sq[$];
      logic [4:0] ev[$];
      logic [4:0] got, e;
      // ALU op writing $7 in EX, Rs=7: single bubble, then not-taken
      sq.push_back(st(0, 5'd7, 5'd1, 1, 0, 0, 0, 1, 5'd7, 0, 5'd0)); ev.push_back(E_BR);
      sq.push_back(st(0, 5'd7, 5'd1, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      // same with destination $0: no stall, taken branch flushes
      sq.push_back(st(0, 5'd7, 5'd1, 1, 1, 0, 0, 1, 5'd0, 0, 5'd0)); ev.push_back(E_FL);
      // ALU dependency without a branch is not a hazard
      sq.push_back(st(0, 5'd7, 5'd1, 0, 0, 0, 0, 1, 5'd7, 0, 5'd0)); ev.push_back(E_OK);
      // load in MEM feeding a branch: single bubble
      sq.push_back(st(0, 5'd3, 5'd9, 1, 1, 0, 0, 0, 5'd0, 1, 5'd9)); ev.push_back(E_BR);
      sq.push_back(st(0, 5'd3, 5'd9, 1, 1, 0, 0, 0, 5'd0, 0, 5'd9)); ev.push_back(E_FL);
      foreach (sq[i]) begin
         @(negedge clk);
         apply(sq[i]);
         exp_q.push_back(ev[i]);
         #1;
         got = observed();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL br_alu_mem[%0d] got=%b expected=%b", i, got, e);
         end
      end
   endtask

   task automatic test_jump();
      stim_t sq[$];
      logic [4:0] ev[$];
      logic [4:0] got, e;
      sq.push_back(st(0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_FL);
      // stall wins over the jump flush
      sq.push_back(st(0, 5'd4, 5'd0, 0, 0, 1, 1, 1, 5'd4, 0, 5'd0)); ev.push_back(E_LW);
      sq.push_back(st(0, 5'd4, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1, 5'd4)); ev.push_back(E_FL);
      foreach (sq[i]) begin
         @(negedge clk);
         apply(sq[i]);
         exp_q.push_back(ev[i]);
         #1;
         got = observed();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL jump[%0d] got=%b expected=%b", i, got, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t sq[$];
      logic [4:0] ev[$];
      logic [4:0] got, e;
      sq.push_back(st(0, 5'd2, 5'd0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0)); ev.push_back(E_LW);
      sq.push_back(st(0, 5'd3, 5'd0, 0, 0, 0, 1, 1, 5'd3, 0, 5'd0)); ev.push_back(E_LW);
      sq.push_back(st(0, 5'd6, 5'd0, 1, 0, 0, 0, 1, 5'd6, 0, 5'd0)); ev.push_back(E_BR);
      sq.push_back(st(0, 5'd6, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      foreach (sq[i]) begin
         @(negedge clk);
         apply(sq[i]);
         exp_q.push_back(ev[i]);
         #1;
         got = observed();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL back_to_back[%0d] got=%b expected=%b", i, got, e);
         end
      end
   endtask

   task automatic test_reset_in_hold();
      stim_t sq[$];
      logic [4:0] ev[$];
      logic [4:0] got, e;
      sq.push_back(st(0, 5'd5, 5'd0, 1, 0, 0, 1, 1, 5'd5, 0, 5'd0)); ev.push_back(E_BR);
      // now in HOLD: reset forces the outputs and returns the FSM to RUN
      sq.push_back(st(1, 5'd5, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      sq.push_back(st(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(E_OK);
      foreach (sq[i]) begin
         @(negedge clk);
         apply(sq[i]);
         exp_q.push_back(ev[i]);
         #1;
         got = observed();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_in_hold[%0d] got=%b expected=%b", i, got, e);
         end
      end
   endtask

   task automatic test_perf();
`ifdef HAZARD_PERF_EN
      logic [31:0] cq[$];
      @(negedge clk);
      apply(st(1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0));
      @(negedge clk);
      apply(st(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0));
      cq.push_back(32'd0);
      #1;
      checks++;
      if (stall_cycles !== cq.pop_front()) begin
         errors++;
         $display("FAIL perf_stall_clear got=%0d expected=0", stall_cycles);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         apply(st(0, 5'd2, 5'd0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0));
      end
      @(negedge clk);
      apply(st(0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0));
      cq.push_back(32'd3);
      #1;
      checks++;
      if (stall_cycles !== cq.pop_front()) begin
         errors++;
         $display("FAIL perf_stall_count got=%0d expected=3", stall_cycles);
      end
      @(negedge clk);
      apply(st(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0));
      cq.push_back(32'd1);
      #1;
      checks++;
      if (flush_count !== cq.pop_front()) begin
         errors++;
         $display("FAIL perf_flush_count got=%0d expected=1", flush_count);
      end
`endif
   endtask

   initial begin
      apply(st(1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0));
      test_reset();
      test_lw_use();
      test_branch_on_load();
      test_branch_alu_mem();
      test_jump();
      test_back_to_back();
      test_reset_in_hold();
      test_perf();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core; the producer of the ID_Hazard_lwstall and ID_Hazard_Branch inputs consumed by the ID_EX pipeline register. It watches the instructions in IF_ID, ID_EX and EX_MEM. When a result is not yet available it inserts bubbles and holds PC and IF_ID. When a branch is taken or a jump is decoded in ID, it flushes IF. A small state machine sequences the two-cycle stall needed when a branch in ID depends on a load in EX.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- IF_ID_RegisterRs  in  5  source register rs of the instruction in ID
- IF_ID_RegisterRt  in  5  source register rt of the instruction in ID
- ID_Branch  in  1  instruction in ID is a conditional branch
- ID_Branch_taken  in  1  branch comparison result in ID; meaningful only when no stall is asserted
- ID_Jump  in  1  instruction in ID is a jump
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegWrite  in  1  instruction in EX writes a register
- ID_EX_WriteReg  in  5  destination register of the instruction in EX, after RegDst selection
- EX_MEM_MemRead  in  1  instruction in MEM is a load
- EX_MEM_WriteReg  in  5  destination register of the instruction in MEM
- ID_Hazard_lwstall  out  1  load-use bubble into ID_EX
- ID_Hazard_Branch  out  1  branch-dependency bubble into ID_EX
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF_ID update enable
- IF_Flush  out  1  zero IF_ID on the next edge
- stall_cycles  out  32  present only with HAZARD_PERF_EN
- flush_count  out  32  present only with HAZARD_PERF_EN

## Operation
- match(r) = (r != 0) && (r == IF_ID_RegisterRs || r == IF_ID_RegisterRt). Register $0 never causes a hazard.
- Hazard terms, all combinational:
  - lw_use = ID_EX_MemRead && match(ID_EX_WriteReg)
  - br_lw = ID_Branch && ID_EX_MemRead && match(ID_EX_WriteReg)
  - br_alu = ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && match(ID_EX_WriteReg)
  - br_mem = ID_Branch && EX_MEM_MemRead && match(EX_MEM_WriteReg)
- FSM states:
  - RUN: stall = lw_use || br_lw || br_alu || br_mem.
    - Next state is HOLD if br_lw, otherwise RUN.
  - HOLD: stall = 1 unconditionally. Next state is RUN.
- Stall outputs, applied whenever stall = 1:
  - PC_Write = 0, IF_ID_Write = 0, IF_Flush = 0.
  - ID_Hazard_Branch = 1 if the state is HOLD or ID_Branch = 1.
  - Otherwise ID_Hazard_lwstall = 1.
  - ID_Hazard_lwstall and ID_Hazard_Branch are never both 1.
- Normal operation (stall = 0):
  - PC_Write = 1, IF_ID_Write = 1, both hazard outputs = 0.
  - IF_Flush = ID_Jump || (ID_Branch && ID_Branch_taken).
- A stall always takes priority over a flush. A branch is resolved only in the first non-stalled cycle.
- While rst = 1:
  - Outputs are forced to ID_Hazard_lwstall = 0, ID_Hazard_Branch = 0, IF_Flush = 0, PC_Write = 1, IF_ID_Write = 1.
  - The state loads RUN on the edge.
- Reset asserted while in HOLD aborts the stall. The next cycle is RUN with no residual stall.

## Timing
- All outputs depend combinationally on the current inputs and state, so there is zero-cycle latency to the ID_EX, PC and IF_ID enables in the same cycle.
- State is the only register, plus the optional counters.
- Stall length per hazard:
  - lw_use: 1 cycle.
  - br_alu: 1 cycle.
  - br_mem: 1 cycle.
  - br_lw: 2 cycles. RUN cycle plus HOLD cycle. In the HOLD cycle the load is in MEM, so br_mem is also true; this is consistent and produces no third cycle.
- Back-to-back hazards are re-evaluated every RUN cycle. No cycle is lost between consecutive independent stalls.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every cycle with stall = 1.
  - flush_count increments on every cycle with IF_Flush = 1.
  - Both counters saturate at 32'hFFFFFFFF and clear synchronously on rst.
- HAZARD_PERF_EN undefined: both counter ports and their logic are absent. All other behaviour is identical.

## Test plan
- lw $2 in EX (ID_EX_MemRead = 1, ID_EX_WriteReg = 2), IF_ID_RegisterRs = 2 → exactly one cycle of ID_Hazard_lwstall = 1, PC_Write = 0, IF_ID_Write = 0; the next cycle has all hazard outputs clear.
- beq in ID (ID_Branch = 1) with lw $5 in EX, IF_ID_RegisterRt = 5, then the load advances to MEM → ID_Hazard_Branch = 1 for 2 cycles; the third cycle with ID_Branch_taken = 1 gives IF_Flush = 1 and PC_Write = 1.
- Branch in ID, ALU op writing $7 in EX, Rs = 7 → 1-cycle ID_Hazard_Branch. Same stimulus with ID_EX_WriteReg = 0 → no stall.
- ID_Jump = 1 with no dependencies → IF_Flush = 1 in the same cycle, no stall. With lw_use also true → IF_Flush = 0 and ID_Hazard_lwstall = 1.
- rst = 1 asserted during HOLD → after that edge the state is RUN and outputs are at their reset values; with HAZARD_PERF_EN, stall_cycles = 0 after reset, and after three stall cycles reads 3.
